// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse packet assembler.
package ps2_pkg;

    typedef enum logic [1:0] {
        WAIT_B0,
        WAIT_B1,
        WAIT_B2
    } ps2_state_t;

    // Bit 3 of a mouse status byte is always set, which is how byte 0 is recognised.
    localparam int SYNC_BIT = 3;

    localparam int BYTE_W     = 8;
    localparam int STATUS_LSB = 0;
    localparam int X_LSB      = 8;
    localparam int Y_LSB      = 16;

    localparam int DEFAULT_TIMEOUT_CYC = 100000;

endpackage

// File: rtl/ps2_byte_timer.sv
// Inter-byte timeout counter; expire flags the last idle cycle before a packet is abandoned.
module ps2_byte_timer #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clk_sys,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_sys) begin
        if (rst || clear || !enable) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/ps2_packet_assembler.sv
// Assembles three PS/2 mouse bytes into a 24-bit packet, dropping partial packets on error or timeout.
module ps2_packet_assembler
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
    parameter int CNT_W       = 16
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              byte_vld,
    input  logic [7:0]        byte_data,
    input  logic              byte_err,
    output logic              rd_vld,
    output logic [23:0]       rd_data,
    output logic              pkt_drop,
    output logic [CNT_W-1:0]  pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    ps2_state_t        state;
    logic [BYTE_W-1:0] status_q;
    logic [BYTE_W-1:0] x_q;
    logic              expire;

    ps2_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk_sys(clk_sys),
        .rst    (rst),
        .clear  (byte_vld),
        .enable (state != WAIT_B0),
        .expire (expire)
    );

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            state    <= WAIT_B0;
            status_q <= '0;
            x_q      <= '0;
            rd_vld   <= 1'b0;
            rd_data  <= '0;
            pkt_drop <= 1'b0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            rd_vld   <= 1'b0;
            pkt_drop <= 1'b0;
            case (state)
                WAIT_B0: begin
                    if (byte_vld && !byte_err && byte_data[SYNC_BIT]) begin
                        status_q <= byte_data;
                        state    <= WAIT_B1;
                    end
                end
                WAIT_B1: begin
                    if (byte_vld && !byte_err) begin
                        x_q   <= byte_data;
                        state <= WAIT_B2;
                    end else if (byte_vld || expire) begin
                        state    <= WAIT_B0;
                        pkt_drop <= 1'b1;
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                WAIT_B2: begin
                    if (byte_vld && !byte_err) begin
                        rd_data[STATUS_LSB +: BYTE_W] <= status_q;
                        rd_data[X_LSB +: BYTE_W]      <= x_q;
                        rd_data[Y_LSB +: BYTE_W]      <= byte_data;
                        rd_vld  <= 1'b1;
                        pkt_cnt <= pkt_cnt + 1'b1;
                        state   <= WAIT_B0;
                    end else if (byte_vld || expire) begin
                        state    <= WAIT_B0;
                        pkt_drop <= 1'b1;
                        drop_cnt <= drop_cnt + 1'b1;
                    end
                end
                default: state <= WAIT_B0;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_packet_assembler.sv
// Self-checking bench: directed packet scenarios plus random byte streams against a queue-based model.
module tb_ps2_packet_assembler;

    localparam int T  = 20;
    localparam int CW = 4;

    logic          clk_sys = 1'b0;
    logic          rst = 1'b1;
    logic          byte_vld = 1'b0;
    logic [7:0]    byte_data = 8'h00;
    logic          byte_err = 1'b0;
    logic          rd_vld;
    logic [23:0]   rd_data;
    logic          pkt_drop;
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0]    partial[$];
    int            idle = 0;
    logic          exp_vld = 1'b0;
    logic          exp_drop = 1'b0;
    logic [23:0]   exp_data = 24'h0;
    logic [CW-1:0] exp_pkt = '0;
    logic [CW-1:0] exp_dcnt = '0;

    ps2_packet_assembler #(
        .TIMEOUT_CYC(T),
        .CNT_W      (CW)
    ) dut (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .byte_vld (byte_vld),
        .byte_data(byte_data),
        .byte_err (byte_err),
        .rd_vld   (rd_vld),
        .rd_data  (rd_data),
        .pkt_drop (pkt_drop),
        .pkt_cnt  (pkt_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // Model works on the bytes gathered since the last sync byte and the idle gap since the last byte.
    task automatic model_step(input logic v, input logic [7:0] d, input logic e);
        exp_vld  = 1'b0;
        exp_drop = 1'b0;
        if (rst) begin
            partial.delete();
            idle     = 0;
            exp_data = 24'h0;
            exp_pkt  = '0;
            exp_dcnt = '0;
            return;
        end
        if (v) begin
            idle = 0;
            if (partial.size() == 0) begin
                if (!e && d[3]) partial.push_back(d);
            end else if (e) begin
                partial.delete();
                exp_drop = 1'b1;
                exp_dcnt = exp_dcnt + 1'b1;
            end else begin
                partial.push_back(d);
                if (partial.size() == 3) begin
                    exp_data = {partial[2], partial[1], partial[0]};
                    exp_vld  = 1'b1;
                    exp_pkt  = exp_pkt + 1'b1;
                    partial.delete();
                end
            end
        end else if (partial.size() != 0) begin
            idle++;
            if (idle >= T) begin
                partial.delete();
                idle     = 0;
                exp_drop = 1'b1;
                exp_dcnt = exp_dcnt + 1'b1;
            end
        end
    endtask

    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic e);
        byte_vld  = v;
        byte_data = d;
        byte_err  = e;
        @(posedge clk_sys);
        model_step(v, d, e);
        #1;
        byte_vld  = 1'b0;
        byte_data = 8'h00;
        byte_err  = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'h18, 1'b0);
        rst = 1'b0;
        checks += 5;
        if (rd_vld !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_vld: got %b expected 0", rd_vld); end
        if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL reset_pkt_drop: got %b expected 0", pkt_drop); end
        if (rd_data !== 24'h0) begin failures++; $display("[TB] FAIL reset_rd_data: got %h expected 000000", rd_data); end
        if (pkt_cnt !== '0) begin failures++; $display("[TB] FAIL reset_pkt_cnt: got %0d expected 0", pkt_cnt); end
        if (drop_cnt !== '0) begin failures++; $display("[TB] FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_basic_packet;
        drive_cycle(1'b1, 8'h09, 1'b0);
        idle_cycles(1);
        drive_cycle(1'b1, 8'h05, 1'b0);
        idle_cycles(1);
        drive_cycle(1'b1, 8'hFB, 1'b0);
        checks += 3;
        if (rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL basic_rd_vld: got %b expected 1", rd_vld); end
        if (rd_data !== 24'hFB0509) begin failures++; $display("[TB] FAIL basic_rd_data: got %h expected fb0509", rd_data); end
        if (pkt_cnt !== 4'd1) begin failures++; $display("[TB] FAIL basic_pkt_cnt: got %0d expected 1", pkt_cnt); end
        idle_cycles(2);
        checks += 2;
        if (rd_vld !== 1'b0) begin failures++; $display("[TB] FAIL basic_single_pulse: got %b expected 0", rd_vld); end
        if (rd_data !== 24'hFB0509) begin failures++; $display("[TB] FAIL basic_data_held: got %h expected fb0509", rd_data); end
    endtask

    task automatic test_sync_discard;
        drive_cycle(1'b1, 8'h00, 1'b0);
        checks += 1;
        if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL sync_no_drop: got %b expected 0", pkt_drop); end
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'h10, 1'b0);
        drive_cycle(1'b1, 8'h20, 1'b0);
        checks += 3;
        if (rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL sync_rd_vld: got %b expected 1", rd_vld); end
        if (rd_data !== 24'h201008) begin failures++; $display("[TB] FAIL sync_rd_data: got %h expected 201008", rd_data); end
        if (pkt_cnt !== 4'd2) begin failures++; $display("[TB] FAIL sync_pkt_cnt: got %0d expected 2", pkt_cnt); end
    endtask

    task automatic test_timeout;
        logic seen_drop;
        seen_drop = 1'b0;
        drive_cycle(1'b1, 8'h08, 1'b0);
        for (int i = 0; i < T - 1; i++) begin
            drive_cycle(1'b0, 8'h00, 1'b0);
            seen_drop |= pkt_drop;
        end
        checks += 1;
        if (seen_drop !== 1'b0) begin failures++; $display("[TB] FAIL timeout_early: got %b expected 0", seen_drop); end
        drive_cycle(1'b0, 8'h00, 1'b0);
        checks += 2;
        if (pkt_drop !== 1'b1) begin failures++; $display("[TB] FAIL timeout_drop: got %b expected 1", pkt_drop); end
        if (drop_cnt !== 4'd1) begin failures++; $display("[TB] FAIL timeout_drop_cnt: got %0d expected 1", drop_cnt); end
        idle_cycles(1);
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h02, 1'b0);
        checks += 2;
        if (rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL timeout_next_vld: got %b expected 1", rd_vld); end
        if (rd_data !== 24'h020108) begin failures++; $display("[TB] FAIL timeout_next_data: got %h expected 020108", rd_data); end
    endtask

    task automatic test_byte_error;
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'h11, 1'b1);
        checks += 3;
        if (pkt_drop !== 1'b1) begin failures++; $display("[TB] FAIL err_drop: got %b expected 1", pkt_drop); end
        if (rd_vld !== 1'b0) begin failures++; $display("[TB] FAIL err_no_vld: got %b expected 0", rd_vld); end
        if (drop_cnt !== 4'd2) begin failures++; $display("[TB] FAIL err_drop_cnt: got %0d expected 2", drop_cnt); end
        drive_cycle(1'b1, 8'h18, 1'b0);
        drive_cycle(1'b1, 8'h22, 1'b0);
        drive_cycle(1'b1, 8'h33, 1'b0);
        checks += 3;
        if (rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL err_next_vld: got %b expected 1", rd_vld); end
        if (rd_data !== 24'h332218) begin failures++; $display("[TB] FAIL err_next_data: got %h expected 332218", rd_data); end
        if (pkt_cnt !== 4'd4) begin failures++; $display("[TB] FAIL err_pkt_cnt: got %0d expected 4", pkt_cnt); end
    endtask

    task automatic test_expiry_race;
        drive_cycle(1'b1, 8'h08, 1'b0);
        idle_cycles(T - 1);
        drive_cycle(1'b1, 8'h44, 1'b0);
        checks += 1;
        if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL race_no_drop: got %b expected 0", pkt_drop); end
        drive_cycle(1'b1, 8'h55, 1'b0);
        checks += 2;
        if (rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL race_vld: got %b expected 1", rd_vld); end
        if (rd_data !== 24'h554408) begin failures++; $display("[TB] FAIL race_data: got %h expected 554408", rd_data); end
    endtask

    task automatic test_reset_mid_packet;
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'h12, 1'b0);
        rst = 1'b1;
        drive_cycle(1'b1, 8'h34, 1'b0);
        rst = 1'b0;
        checks += 5;
        if (rd_vld !== 1'b0) begin failures++; $display("[TB] FAIL midrst_rd_vld: got %b expected 0", rd_vld); end
        if (pkt_drop !== 1'b0) begin failures++; $display("[TB] FAIL midrst_pkt_drop: got %b expected 0", pkt_drop); end
        if (rd_data !== 24'h0) begin failures++; $display("[TB] FAIL midrst_rd_data: got %h expected 000000", rd_data); end
        if (pkt_cnt !== '0) begin failures++; $display("[TB] FAIL midrst_pkt_cnt: got %0d expected 0", pkt_cnt); end
        if (drop_cnt !== '0) begin failures++; $display("[TB] FAIL midrst_drop_cnt: got %0d expected 0", drop_cnt); end
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'hAA, 1'b0);
        drive_cycle(1'b1, 8'hBB, 1'b0);
        checks += 3;
        if (rd_data !== 24'hBBAA08) begin failures++; $display("[TB] FAIL midrst_next_data: got %h expected bbaa08", rd_data); end
        if (pkt_cnt !== 4'd1) begin failures++; $display("[TB] FAIL midrst_next_cnt: got %0d expected 1", pkt_cnt); end
        if (drop_cnt !== '0) begin failures++; $display("[TB] FAIL midrst_next_drop: got %0d expected 0", drop_cnt); end
    endtask

    task automatic test_back_to_back;
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'h01, 1'b0);
        drive_cycle(1'b1, 8'h02, 1'b0);
        checks += 2;
        if (rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL b2b_first_vld: got %b expected 1", rd_vld); end
        if (rd_data !== 24'h020108) begin failures++; $display("[TB] FAIL b2b_first_data: got %h expected 020108", rd_data); end
        drive_cycle(1'b1, 8'h09, 1'b0);
        checks += 1;
        if (rd_vld !== 1'b0) begin failures++; $display("[TB] FAIL b2b_gap_vld: got %b expected 0", rd_vld); end
        drive_cycle(1'b1, 8'h03, 1'b0);
        drive_cycle(1'b1, 8'h04, 1'b0);
        checks += 2;
        if (rd_vld !== 1'b1) begin failures++; $display("[TB] FAIL b2b_second_vld: got %b expected 1", rd_vld); end
        if (rd_data !== 24'h040309) begin failures++; $display("[TB] FAIL b2b_second_data: got %h expected 040309", rd_data); end
    endtask

    task automatic test_random;
        int         gap_left;
        logic       v;
        logic       e;
        logic [7:0] d;
        gap_left = 0;
        for (int i = 0; i < 1500; i++) begin
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) d[3] = 1'b1;
            e = ($urandom_range(0, 11) == 0);
            if (gap_left > 0) begin
                gap_left--;
                v = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
                gap_left = $urandom_range(T - 2, T + 1);
                v = 1'b0;
            end else begin
                v = ($urandom_range(0, 2) != 0);
            end
            drive_cycle(v, d, e);
            checks += 6;
            if (rd_vld !== exp_vld) begin failures++; $display("[TB] FAIL rand_rd_vld cyc %0d: got %b expected %b", i, rd_vld, exp_vld); end
            if (pkt_drop !== exp_drop) begin failures++; $display("[TB] FAIL rand_pkt_drop cyc %0d: got %b expected %b", i, pkt_drop, exp_drop); end
            if (rd_data !== exp_data) begin failures++; $display("[TB] FAIL rand_rd_data cyc %0d: got %h expected %h", i, rd_data, exp_data); end
            if (pkt_cnt !== exp_pkt) begin failures++; $display("[TB] FAIL rand_pkt_cnt cyc %0d: got %0d expected %0d", i, pkt_cnt, exp_pkt); end
            if (drop_cnt !== exp_dcnt) begin failures++; $display("[TB] FAIL rand_drop_cnt cyc %0d: got %0d expected %0d", i, drop_cnt, exp_dcnt); end
            if ((rd_vld & pkt_drop) !== 1'b0) begin failures++; $display("[TB] FAIL rand_exclusive cyc %0d: got vld=%b drop=%b expected not both", i, rd_vld, pkt_drop); end
        end
    endtask

    task automatic test_wrap;
        rst = 1'b1;
        drive_cycle(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        for (int p = 0; p < (1 << CW); p++) begin
            drive_cycle(1'b1, 8'h08, 1'b0);
            drive_cycle(1'b1, 8'(p), 1'b0);
            drive_cycle(1'b1, 8'h7E, 1'b0);
        end
        checks += 1;
        if (pkt_cnt !== '0) begin failures++; $display("[TB] FAIL wrap_all_ones: got %0d expected 0", pkt_cnt); end
        drive_cycle(1'b1, 8'h08, 1'b0);
        drive_cycle(1'b1, 8'h66, 1'b0);
        drive_cycle(1'b1, 8'h77, 1'b0);
        checks += 2;
        if (pkt_cnt !== 4'd1) begin failures++; $display("[TB] FAIL wrap_to_one: got %0d expected 1", pkt_cnt); end
        if (rd_data !== 24'h776608) begin failures++; $display("[TB] FAIL wrap_data: got %h expected 776608", rd_data); end
    endtask

    initial begin
        #1;
        test_reset;
        test_basic_packet;
        test_sync_discard;
        test_timeout;
        test_byte_error;
        test_expiry_race;
        test_reset_mid_packet;
        test_back_to_back;
        test_random;
        test_wrap;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/ps2_packet_assembler.md
PS2_PACKET_ASSEMBLER -- requirements
Module: ps2_packet_assembler

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 100000, inter-byte timeout in clk_sys cycles (2 ms at 50 MHz).
REQ-002 Parameter: CNT_W, default 16, width of packet/drop counters.
REQ-003 clk_sys  input  1  50 MHz system clock; sole clock domain.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 byte_vld  input  1  one-cycle strobe, a PS/2 byte was received.
REQ-006 byte_data  input  8  received byte, valid with byte_vld.
REQ-007 byte_err  input  1  parity/frame error flag for the byte, valid with byte_vld.
REQ-008 rd_vld  output  1  one-cycle strobe, complete 3-byte mouse packet on rd_data.
REQ-009 rd_data  output  24  packet: [7:0] status byte, [15:8] X movement, [23:16] Y movement.
REQ-010 pkt_drop  output  1  one-cycle strobe, partial packet discarded.
REQ-011 pkt_cnt  output  CNT_W  count of delivered packets, wraps.
REQ-012 drop_cnt  output  CNT_W  count of pkt_drop strobes, wraps.

Function
REQ-013 FSM states: WAIT_B0, WAIT_B1, WAIT_B2; reset state WAIT_B0.
REQ-014 WAIT_B0: byte_vld, byte_err=0, byte_data[3]=1 -> latch status byte, go WAIT_B1; any other byte discarded silently, stay, no pkt_drop.
REQ-015 WAIT_B1: byte_vld, byte_err=0 -> latch X byte, go WAIT_B2.
REQ-016 WAIT_B2: byte_vld, byte_err=0 -> latch Y byte, go WAIT_B0, deliver packet.
REQ-017 Delivery: rd_vld high exactly one cycle, the cycle after the accepting byte_vld; rd_data updated in that same cycle and held stable until the next delivery.
REQ-018 byte_err=1 with byte_vld in WAIT_B1/WAIT_B2 -> go WAIT_B0, pulse pkt_drop next cycle, latched partial bytes not delivered.
REQ-019 Timeout counter: cleared on every byte_vld, increments each cycle in WAIT_B1/WAIT_B2, held at 0 in WAIT_B0.
REQ-020 Counter reaching TIMEOUT_CYC-1 with no byte_vld -> go WAIT_B0, pulse pkt_drop next cycle.
REQ-021 Simultaneous timeout expiry and byte_vld: the byte wins, no timeout, byte processed per REQ-015/016/018.
REQ-022 pkt_cnt increments with each rd_vld; drop_cnt with each pkt_drop; both wrap from all-ones to 0.
REQ-023 Back-to-back byte_vld on consecutive cycles is accepted; no byte is lost at any rate.
REQ-024 rd_vld and pkt_drop never assert in the same cycle.

Reset
REQ-025 rst held high at a rising clk_sys edge -> state WAIT_B0, timeout counter 0, rd_vld 0, pkt_drop 0, rd_data 24'h0, pkt_cnt 0, drop_cnt 0.
REQ-026 Reset mid-packet discards the partial packet without a pkt_drop or drop_cnt change.
REQ-027 byte_vld during a reset cycle is ignored.

Structure
REQ-028 Package ps2_pkg holds the FSM state enum, SYNC_BIT=3, byte-field index constants, and the default TIMEOUT_CYC.
REQ-029 One sub-module, ps2_byte_timer (clear/enable inputs, expire output), implements the timeout counter; everything else lives in ps2_packet_assembler.
REQ-030 All outputs are registered; no combinational path from inputs to outputs.

Verification
REQ-031 Bytes 0x09, 0x05, 0xFB, one idle cycle apart -> one rd_vld, rd_data=24'hFB0509, pkt_cnt=1.
REQ-032 Bytes 0x00 then 0x08, 0x10, 0x20 -> 0x00 discarded, no pkt_drop, rd_data=24'h201008.
REQ-033 0x08, then no byte for TIMEOUT_CYC cycles, then 0x08, 0x01, 0x02 -> one pkt_drop, drop_cnt=1, then rd_data=24'h020108.
REQ-034 0x08, 0x11 with byte_err=1, then 0x18, 0x22, 0x33 -> pkt_drop, then rd_data=24'h332218 only.
REQ-035 Byte arrives exactly on the expiry cycle -> no pkt_drop; rst mid-packet -> all outputs 0, next clean packet delivered.
REQ-036 2^CNT_W+1 valid packets -> pkt_cnt wraps to 1.
